// File: rtl/mips_register_file.sv
// MIPS general-purpose register file: two combinational read ports, one clocked
// write port, $0 hardwired to zero, and write-to-read bypass for same-cycle writeback.
module mips_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    logic wr_ok;
    assign wr_ok = wr_en && (wr_addr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass is suppressed during reset so reads show the array, not the discarded write.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        if (addr == '0) begin
            return '0;
        end else if (!reset && wr_ok && (wr_addr == addr)) begin
            return wr_data;
        end else begin
            return regs_q[addr];
        end
    endfunction

    always_comb begin
        rs_data = read_port(rs_addr);
        rt_data = read_port(rt_addr);
    end

endmodule

// File: tb/tb_mips_register_file.sv
// Randomized and directed bench for mips_register_file against an array-based
// model of the architectural register state.
module tb_mips_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    mips_register_file #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rs_addr(rs_addr),
        .rt_addr(rt_addr),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit [DW-1:0] model [32];

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Architectural view of a read: $0 is zero, a live writeback wins, else stored value.
    function automatic bit [DW-1:0] exp_read(input int unsigned a);
        if (a == 0) return 0;
        if (!reset && wr_en && (int'(wr_addr) == a)) return wr_data;
        return model[a];
    endfunction

    task automatic set_in(input bit rst, input bit we, input int unsigned wa, input bit [DW-1:0] wd,
                          input int unsigned ra, input int unsigned rb);
        reset   = rst;
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        rs_addr = AW'(ra);
        rt_addr = AW'(rb);
    endtask

    // Check both ports against the model mid-cycle, then advance one clock.
    task automatic step(input bit chk, input string tag);
        #2;
        if (chk) begin
            check_eq({tag, "_rs"}, rs_data, exp_read(int'(rs_addr)));
            check_eq({tag, "_rt"}, rt_data, exp_read(int'(rt_addr)));
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 0;
        end else if (wr_en && wr_addr != 0) begin
            model[wr_addr] = wr_data;
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        step(0, "reset");

        for (int i = 0; i < 32; i++) begin
            set_in(0, 0, 0, 0, i, 31 - i);
            #2;
            check_eq("sweep_rs", rs_data, 32'h0);
            check_eq("sweep_rt", rt_data, 32'h0);
            step(1, "sweep");
        end

        set_in(0, 1, 5, 32'hDEADBEEF, 0, 0);
        step(1, "wr5");
        set_in(0, 1, 31, 32'h12345678, 0, 0);
        step(1, "wr31");
        set_in(0, 0, 0, 0, 5, 31);
        #2;
        check_eq("rdback_rs5", rs_data, 32'hDEADBEEF);
        check_eq("rdback_rt31", rt_data, 32'h12345678);
        step(1, "rdback");

        set_in(0, 1, 0, 32'hFFFFFFFF, 0, 0);
        #2;
        check_eq("zero_during", rs_data, 32'h0);
        step(1, "zero_wr");
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        check_eq("zero_after", rs_data, 32'h0);
        step(1, "zero_rd");

        set_in(0, 1, 8, 32'h11111111, 0, 0);
        step(1, "pre8");
        set_in(0, 1, 8, 32'h22222222, 8, 8);
        #2;
        check_eq("bypass_rs", rs_data, 32'h22222222);
        check_eq("bypass_rt", rt_data, 32'h22222222);
        step(1, "bypass");
        set_in(0, 0, 8, 32'h33333333, 8, 8);
        #2;
        check_eq("stored8_rs", rs_data, 32'h22222222);
        check_eq("stored8_rt", rt_data, 32'h22222222);
        step(1, "stored8");

        set_in(0, 1, 3, 32'hAAAA5555, 0, 0);
        step(1, "pre3");
        set_in(1, 1, 3, 32'h0F0F0F0F, 3, 3);
        #2;
        check_eq("rstprio_during", rs_data, 32'hAAAA5555);
        step(1, "rstprio");
        set_in(0, 0, 0, 0, 3, 5);
        #2;
        check_eq("rstprio_after3", rs_data, 32'h0);
        check_eq("rstprio_after5", rt_data, 32'h0);
        step(1, "rstclr");

        set_in(0, 0, 10, 32'hCAFEF00D, 10, 10);
        #2;
        check_eq("wren_gate", rs_data, 32'h0);
        step(1, "wren_gate");
        set_in(0, 0, 0, 0, 10, 0);
        #2;
        check_eq("wren_gate_after", rs_data, 32'h0);
        step(1, "wren_gate2");

        for (int n = 0; n < 400; n++) begin
            int unsigned ra, rb, wa;
            bit rst, we;
            ra  = $urandom_range(0, 31);
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 31);
            case ($urandom_range(0, 4))
                0: wa = ra;
                1: wa = rb;
                2: wa = 0;
                3: wa = 31;
                default: wa = $urandom_range(0, 31);
            endcase
            we  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            set_in(rst, we, wa, $urandom, ra, rb);
            step(1, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
